// File: rtl/irq_controller.sv
// Edge-triggered, prioritised interrupt source for the CPU IRQ/IACK handshake.
// It has a memory-mapped PENDING/ENABLE/CLAIM/EOI window and holds the claimed id in service until EOI.
module irq_controller #(
   parameter int          NSRC      = 8,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] src,
   input  logic [31:0]     daddr,
   input  logic [31:0]     dwdata,
   input  logic [3:0]      we,
   output logic [31:0]     drdata,
   output logic            hit,
   output logic            irq,
   input  logic            iack,
   output logic [4:0]      active_id,
   output logic            in_service
);

   typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

   state_t          state_q, state_d;
   logic [NSRC-1:0] src_q, src_d;
   logic [NSRC-1:0] pending_q, pending_d;
   logic [NSRC-1:0] enable_q, enable_d;
   logic [4:0]      active_id_q, active_id_d;
   logic            irq_q, irq_d;
   logic            in_service_q, in_service_d;

   logic [NSRC-1:0] src_edge;
   logic [NSRC-1:0] req_vec;
   logic [NSRC-1:0] active_mask;
   logic [NSRC-1:0] clear_mask;
   logic [4:0]      sel;
   logic            wr_full;
   logic            w1c_wr;
   logic            enable_wr;
   logic            eoi_wr;
   logic            claim;
   logic            unused_bits;

   assign unused_bits = ^{daddr[1:0], dwdata};

   assign hit       = (daddr[31:4] == BASE_ADDR[31:4]);
   assign wr_full   = hit && (we == 4'b1111);
   assign w1c_wr    = wr_full && (daddr[3:2] == 2'd0);
   assign enable_wr = wr_full && (daddr[3:2] == 2'd1);
   assign eoi_wr    = wr_full && (daddr[3:2] == 2'd3);

   assign src_edge    = src & ~src_q;
   assign req_vec     = pending_q & enable_q;
   assign active_mask = NSRC'(1) << active_id_q;

   // Lowest index wins: scan downward so the last assignment is the smallest set bit.
   always_comb begin
      sel = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req_vec[i]) sel = 5'(i);
      end
   end

   always_comb begin
      state_d      = state_q;
      active_id_d  = active_id_q;
      irq_d        = irq_q;
      in_service_d = in_service_q;
      claim        = 1'b0;
      case (state_q)
         IDLE: begin
            irq_d = 1'b0;
            if ((|req_vec) && !iack) begin
               state_d     = REQ;
               active_id_d = sel;
               irq_d       = 1'b1;
            end
         end
         REQ: begin
            if (iack) begin
               state_d      = SVC;
               irq_d        = 1'b0;
               in_service_d = 1'b1;
               claim        = 1'b1;
            end else if (!(|(req_vec & active_mask))) begin
               state_d = IDLE;
               irq_d   = 1'b0;
            end
         end
         SVC: begin
            irq_d = 1'b0;
            if (eoi_wr) begin
               state_d      = IDLE;
               in_service_d = 1'b0;
            end
         end
         default: begin
            state_d      = IDLE;
            irq_d        = 1'b0;
            in_service_d = 1'b0;
         end
      endcase
   end

   // New edges are ORed in after clearing so a same-cycle event is never lost.
   always_comb begin
      clear_mask = '0;
      if (w1c_wr) clear_mask = clear_mask | dwdata[NSRC-1:0];
      if (claim)  clear_mask = clear_mask | active_mask;
      pending_d = (pending_q & ~clear_mask) | src_edge;
      enable_d  = enable_wr ? dwdata[NSRC-1:0] : enable_q;
      src_d     = src;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         src_q        <= '0;
         pending_q    <= '0;
         enable_q     <= '0;
         active_id_q  <= '0;
         irq_q        <= 1'b0;
         in_service_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         pending_q    <= pending_d;
         enable_q     <= enable_d;
         active_id_q  <= active_id_d;
         irq_q        <= irq_d;
         in_service_q <= in_service_d;
      end
   end

   always_comb begin
      drdata = '0;
      if (hit) begin
         case (daddr[3:2])
            2'd0:    drdata[NSRC-1:0] = pending_q;
            2'd1:    drdata[NSRC-1:0] = enable_q;
            2'd2:    drdata = {in_service_q, 26'b0, active_id_q};
            default: drdata = '0;
         endcase
      end
   end

   assign irq        = irq_q;
   assign active_id  = active_id_q;
   assign in_service = in_service_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: a register-access vector table followed by handshake sequences.
module tb_irq_controller;

   localparam logic [31:0] BASE = 32'h0000_0100;
   localparam logic [31:0] A_PEND = BASE + 32'h0;
   localparam logic [31:0] A_EN   = BASE + 32'h4;
   localparam logic [31:0] A_CLM  = BASE + 32'h8;
   localparam logic [31:0] A_EOI  = BASE + 32'hC;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  src = '0;
   logic [31:0] daddr = '0;
   logic [31:0] dwdata = '0;
   logic [3:0]  we = '0;
   logic [31:0] drdata;
   logic        hit;
   logic        irq;
   logic        iack = 1'b0;
   logic [4:0]  active_id;
   logic        in_service;

   int n_checks = 0;
   int n_fail   = 0;

   irq_controller #(.NSRC(8), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .src(src), .daddr(daddr), .dwdata(dwdata), .we(we),
      .drdata(drdata), .hit(hit), .irq(irq), .iack(iack), .active_id(active_id),
      .in_service(in_service)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wen;
      logic        exp_hit;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      daddr = a; dwdata = d; we = 4'hF;
      step();
      we = 4'h0; daddr = '0; dwdata = '0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      daddr = a; we = 4'h0;
      #1;
      v = drdata;
      daddr = '0;
   endtask

   logic [31:0] r;

   initial begin
      vecs[0]  = '{A_EN,         32'hA5,        4'hF, 1'b1, 32'h0};
      vecs[1]  = '{A_EN,         32'h0,         4'h0, 1'b1, 32'hA5};
      vecs[2]  = '{A_EN,         32'h3C,        4'h3, 1'b1, 32'hA5};
      vecs[3]  = '{A_EN,         32'h0,         4'h0, 1'b1, 32'hA5};
      vecs[4]  = '{BASE + 32'h20, 32'h0,        4'h0, 1'b0, 32'h0};
      vecs[5]  = '{BASE + 32'h24, 32'h0,        4'hF, 1'b0, 32'h0};
      vecs[6]  = '{A_EN,         32'h0,         4'h0, 1'b1, 32'hA5};
      vecs[7]  = '{A_EN,         32'hFFFF_FFFF, 4'hF, 1'b1, 32'hA5};
      vecs[8]  = '{A_EN,         32'h0,         4'h0, 1'b1, 32'hFF};
      vecs[9]  = '{A_EOI,        32'h0,         4'h0, 1'b1, 32'h0};
      vecs[10] = '{A_CLM,        32'h0,         4'h0, 1'b1, 32'h0};
      vecs[11] = '{A_EN,         32'h0,         4'hF, 1'b1, 32'hFF};
      vecs[12] = '{A_PEND,       32'h0,         4'h0, 1'b1, 32'h0};

      #1;
      check("reset_irq", 32'(irq), 32'h0);
      check("reset_in_service", 32'(in_service), 32'h0);
      check("reset_active_id", 32'(active_id), 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      step();

      // Register access table: drdata is sampled before the edge, so writes show the old value.
      for (int i = 0; i < 13; i++) begin
         daddr = vecs[i].addr; dwdata = vecs[i].wdata; we = vecs[i].wen;
         #1;
         check($sformatf("vec%0d_hit", i), 32'(hit), 32'(vecs[i].exp_hit));
         check($sformatf("vec%0d_rd", i), drdata, vecs[i].exp_rd);
         step();
      end
      we = '0; daddr = '0; dwdata = '0;

      // 1: single source, full handshake
      wr(A_EN, 32'h01);
      src = 8'h01;
      step();
      rd(A_PEND, r); check("t1_pending_set", r, 32'h01);
      check("t1_irq_not_yet", 32'(irq), 32'h0);
      step();
      check("t1_irq", 32'(irq), 32'h1);
      check("t1_active_id", 32'(active_id), 32'h0);
      iack = 1'b1;
      step();
      iack = 1'b0;
      check("t1_irq_drop", 32'(irq), 32'h0);
      check("t1_in_service", 32'(in_service), 32'h1);
      rd(A_PEND, r); check("t1_pending_clr", r, 32'h0);
      rd(A_CLM, r); check("t1_claim", r, 32'h8000_0000);

      // 2: simultaneous sources, priority then second request after EOI
      wr(A_EN, 32'hFF);
      wr(A_EOI, 32'h0);
      check("t2_eoi_idle", 32'(in_service), 32'h0);
      src = 8'h00; step();
      src = 8'h24; step();
      step();
      check("t2_irq", 32'(irq), 32'h1);
      check("t2_active_2", 32'(active_id), 32'h2);
      iack = 1'b1; step(); iack = 1'b0;
      rd(A_PEND, r); check("t2_pending_left", r, 32'h20);
      wr(A_EOI, 32'h0);
      step();
      check("t2_irq2", 32'(irq), 32'h1);
      check("t2_active_5", 32'(active_id), 32'h5);
      iack = 1'b1; step(); iack = 1'b0;
      wr(A_EOI, 32'h0);
      src = 8'h00; step();

      // 3: request withdrawn by disabling
      src = 8'h08; step();
      step();
      check("t3_irq", 32'(irq), 32'h1);
      check("t3_active_3", 32'(active_id), 32'h3);
      wr(A_EN, 32'h0);
      step();
      check("t3_irq_withdrawn", 32'(irq), 32'h0);
      check("t3_not_in_service", 32'(in_service), 32'h0);
      rd(A_PEND, r); check("t3_pending_kept", r, 32'h08);
      rd(A_CLM, r); check("t3_claim", r, 32'h3);
      wr(A_PEND, 32'h08);
      src = 8'h00;
      wr(A_EN, 32'hFF);
      rd(A_PEND, r); check("t3_w1c", r, 32'h0);

      // 4: edge beats same-cycle W1C while in service
      src = 8'h01; step();
      step();
      iack = 1'b1; step(); iack = 1'b0;
      check("t4_svc", 32'(in_service), 32'h1);
      src = 8'h03;
      daddr = A_PEND; dwdata = 32'h02; we = 4'hF;
      step();
      we = '0; daddr = '0; dwdata = '0;
      rd(A_PEND, r); check("t4_set_wins", r, 32'h02);
      step(); step();
      check("t4_no_irq_in_svc", 32'(irq), 32'h0);
      iack = 1'b1;
      wr(A_EOI, 32'h0);
      check("t4_eoi", 32'(in_service), 32'h0);
      step();
      check("t4_iack_gate", 32'(irq), 32'h0);
      iack = 1'b0;
      step();
      check("t4_irq_after", 32'(irq), 32'h1);
      check("t4_active_1", 32'(active_id), 32'h1);
      // EOI coinciding with iack is dropped
      iack = 1'b1;
      wr(A_EOI, 32'h0);
      iack = 1'b0;
      check("t4_eoi_with_iack", 32'(in_service), 32'h1);
      step();
      check("t4_still_svc", 32'(in_service), 32'h1);
      wr(A_EOI, 32'h0);
      check("t4_final_eoi", 32'(in_service), 32'h0);
      src = 8'h00; step();

      // 6: asynchronous reset mid-request
      src = 8'h81; step();
      step();
      check("t6_irq", 32'(irq), 32'h1);
      rd(A_PEND, r); check("t6_pending", r, 32'h81);
      #2 reset = 1'b1;
      #1;
      check("t6_irq_async", 32'(irq), 32'h0);
      check("t6_in_service", 32'(in_service), 32'h0);
      rd(A_PEND, r); check("t6_pending_lost", r, 32'h0);
      rd(A_EN, r); check("t6_enable_lost", r, 32'h0);
      reset = 1'b0;
      src = 8'h00;
      step(); step();
      check("t6_stays_idle", 32'(irq), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
